// File: rtl/uart_os_defs_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_os_defs;

  localparam int unsigned MIN_DATA_BITS = 5;
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } RxState_t;

  typedef struct packed {
    logic brk;
    logic frame;
    logic parity;
  } RxErr_t;

endpackage

// File: rtl/uart_os_fifo.sv
// Generic first-word-fall-through synchronous FIFO with registered level/full/empty.
module uart_os_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count_n;
  logic             wr_c, rd_c;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
  assign rd_c    = pop && !empty;
  assign wr_c    = push && (!full || rd_c);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_n = level;
    if (wr_c && !rd_c)      count_n = level + LW'(1);
    else if (!wr_c && rd_c) count_n = level - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_c) rd_ptr <= rd_ptr + AW'(1);
      level <= count_n;
      full  <= (count_n == LW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchroniser, tick divider, framing FSM, FWFT FIFO and RTS.
module uart_rx_os
  import uart_os_defs::*;
#(
  parameter int unsigned DATA_MAX   = 9,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned RTS_MARGIN = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic [DIV_W-1:0]              divider_i,
  input  logic [3:0]                    data_bits_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  input  logic                          rx_i,
  output logic                          rts_n_o,
  output logic [DATA_MAX-1:0]           d_o,
  output logic [2:0]                    d_err_o,
  output logic                          d_valid_o,
  input  logic                          d_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          overrun_o,
  input  logic                          overrun_clr_i,
  output logic                          break_o
);

  localparam int unsigned SC_W  = $clog2(OVERSAMPLE);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = DATA_MAX + $bits(RxErr_t);
  localparam logic [SC_W-1:0] S_LO  = SC_W'(OVERSAMPLE/2 - 1);
  localparam logic [SC_W-1:0] S_MID = SC_W'(OVERSAMPLE/2);
  localparam logic [SC_W-1:0] S_HI  = SC_W'(OVERSAMPLE/2 + 1);
  localparam logic [SC_W-1:0] S_END = SC_W'(OVERSAMPLE - 1);

  RxState_t            state_q, state_n;
  logic                rx_m, rx_s, rx_d;
  logic [DIV_W-1:0]    div_cnt, div_last;
  logic [SC_W-1:0]     samp_cnt;
  logic                s_lo, s_mid;
  logic                tick_c, decide_c, bit_end_c, maj_c;
  logic [3:0]          nbits_c, nbits_q, bit_idx;
  logic                par_en_q, par_odd_q, stop2_q, stop_idx;
  logic [DATA_MAX-1:0] data_q;
  logic                par_bit_q, frame_q, par_err_c;
  logic                start_c, push_c, brk_c, pop_c, ovf_c;
  RxErr_t              ent_err_c;
  logic [ENT_W-1:0]    rd_data;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // >= keeps the divider from running away if divider_i shrinks mid-count.
  assign div_last = (divider_i == '0) ? '0 : divider_i - DIV_W'(1);
  assign tick_c   = (div_cnt >= div_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
      s_lo     <= 1'b1;
      s_mid    <= 1'b1;
    end else if (start_c) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else begin
      div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      if (tick_c) begin
        samp_cnt <= (samp_cnt == S_END) ? '0 : samp_cnt + SC_W'(1);
        if (samp_cnt == S_LO)  s_lo  <= rx_s;
        if (samp_cnt == S_MID) s_mid <= rx_s;
      end
    end
  end

  assign decide_c  = tick_c && (samp_cnt == S_HI);
  assign bit_end_c = tick_c && (samp_cnt == S_END);
  assign maj_c     = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
  assign par_err_c = par_en_q && ((^data_q ^ par_bit_q) != par_odd_q);

  always_comb begin
    nbits_c = data_bits_i;
    if (data_bits_i < 4'(MIN_DATA_BITS))      nbits_c = 4'(MIN_DATA_BITS);
    else if (data_bits_i > 4'(MAX_DATA_BITS)) nbits_c = 4'(MAX_DATA_BITS);
  end

  // Frame format is captured at the start edge and held for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nbits_q   <= 4'(MIN_DATA_BITS);
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      data_q    <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      par_bit_q <= 1'b0;
      frame_q   <= 1'b0;
    end else if (start_c) begin
      nbits_q   <= nbits_c;
      par_en_q  <= parity_en_i;
      par_odd_q <= parity_odd_i;
      stop2_q   <= stop2_i;
      data_q    <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      par_bit_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      if (decide_c && state_q == DATA)          data_q    <= data_q | (DATA_MAX'(maj_c) << bit_idx);
      if (decide_c && state_q == PARITY)        par_bit_q <= maj_c;
      if (decide_c && state_q == STOP && !maj_c) frame_q  <= 1'b1;
      if (bit_end_c && state_q == DATA)         bit_idx   <= bit_idx + 4'd1;
      if (bit_end_c && state_q == STOP)         stop_idx  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    start_c   = 1'b0;
    push_c    = 1'b0;
    brk_c     = 1'b0;
    ent_err_c = '0;
    unique case (state_q)
      IDLE: begin
        if (rx_d && !rx_s) begin
          state_n = START;
          start_c = 1'b1;
        end
      end
      START: begin
        if (decide_c && maj_c) state_n = IDLE;
        else if (bit_end_c)    state_n = DATA;
      end
      DATA: begin
        if (bit_end_c && bit_idx == nbits_q - 4'd1) state_n = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end_c) state_n = STOP;
      end
      STOP: begin
        // Push at the decision of the last stop bit so the next start edge is not missed.
        if (decide_c) begin
          if (!stop_idx && !maj_c && data_q == '0 && !(par_en_q && par_bit_q)) begin
            push_c    = 1'b1;
            brk_c     = 1'b1;
            ent_err_c = '{brk: 1'b1, frame: 1'b1, parity: 1'b0};
            state_n   = BREAK_WAIT;
          end else if (stop_idx == stop2_q) begin
            push_c           = 1'b1;
            ent_err_c.frame  = frame_q | !maj_c;
            ent_err_c.parity = par_err_c;
            state_n          = IDLE;
          end
        end
      end
      BREAK_WAIT: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (!enable_i) begin
      state_n = IDLE;
      start_c = 1'b0;
      push_c  = 1'b0;
      brk_c   = 1'b0;
    end
  end

  assign d_valid_o = !empty_o;
  assign pop_c     = d_valid_o && d_ready_i;
  assign ovf_c     = push_c && full_o && !pop_c;

  uart_os_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_c),
    .wr_data ({ent_err_c, data_q}),
    .pop     (pop_c),
    .rd_data (rd_data),
    .level   (level_o),
    .full    (full_o),
    .empty   (empty_o)
  );

  assign d_o     = rd_data[DATA_MAX-1:0];
  assign d_err_o = rd_data[ENT_W-1 -: 3];

  // Overrun set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_o <= 1'b0;
      break_o   <= 1'b0;
      rts_n_o   <= 1'b1;
    end else begin
      if (ovf_c)              overrun_o <= 1'b1;
      else if (overrun_clr_i) overrun_o <= 1'b0;
      break_o <= brk_c;
      rts_n_o <= !enable_i || (level_o >= LVL_W'(FIFO_DEPTH - RTS_MARGIN));
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed frame table, multi-cycle corner sequences, randomised frames vs. model.
module tb_uart_rx_os;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0;
  logic [15:0] divider_i = 16'd4;
  logic [3:0]  data_bits_i = 4'd8;
  logic        parity_en_i = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        stop2_i = 1'b0;
  logic        rx_i = 1'b1;
  logic        d_ready_i = 1'b0;
  logic        overrun_clr_i;
  logic        clr_pulse = 1'b0;
  logic        clr_arm = 1'b0;
  logic        rts_n_o, d_valid_o, full_o, empty_o, overrun_o, break_o;
  logic [8:0]  d_o;
  logic [2:0]  d_err_o;
  logic [2:0]  level_o;

  int n_total = 0;
  int n_pass  = 0;
  int brk_cnt = 0;

  // An armed clear drops by itself once overrun_o is seen high.
  assign overrun_clr_i = clr_pulse | (clr_arm & ~overrun_o);

  uart_rx_os #(
    .DATA_MAX   (9),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (4),
    .DIV_W      (16),
    .RTS_MARGIN (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable_i),
    .divider_i     (divider_i),
    .data_bits_i   (data_bits_i),
    .parity_en_i   (parity_en_i),
    .parity_odd_i  (parity_odd_i),
    .stop2_i       (stop2_i),
    .rx_i          (rx_i),
    .rts_n_o       (rts_n_o),
    .d_o           (d_o),
    .d_err_o       (d_err_o),
    .d_valid_o     (d_valid_o),
    .d_ready_i     (d_ready_i),
    .level_o       (level_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .overrun_o     (overrun_o),
    .overrun_clr_i (overrun_clr_i),
    .break_o       (break_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (break_o) brk_cnt++;

  typedef struct {
    logic [3:0] dbits_cfg;
    int         nsend;
    logic [8:0] data;
    logic       pen, podd, pbit, stop1, s2;
    int         div;
    logic [8:0] exp_d;
    logic [2:0] exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_fmt(input int dbits, input logic pen, input logic podd, input logic s2, input int div);
    data_bits_i  = 4'(dbits);
    parity_en_i  = pen;
    parity_odd_i = podd;
    stop2_i      = s2;
    divider_i    = 16'(div);
    cycles(2);
  endtask

  // Serial frame: start, nsend data bits LSB first, optional parity, stop(s), then idle.
  task automatic send_frame(input logic [8:0] data, input int nsend, input logic pen, input logic pbit,
                            input logic stop1, input logic s2, input int div);
    int per;
    per = OS * ((div == 0) ? 1 : div);
    rx_i = 1'b0; cycles(per);
    for (int i = 0; i < nsend; i++) begin
      rx_i = data[i]; cycles(per);
    end
    if (pen) begin rx_i = pbit; cycles(per); end
    rx_i = stop1; cycles(per);
    if (s2) begin rx_i = 1'b1; cycles(per); end
    rx_i = 1'b1; cycles(per + 8);
  endtask

  task automatic pop_check(input string name, input logic [8:0] ed, input logic [2:0] ee);
    chk({name, ".valid"}, 32'(d_valid_o), 32'd1);
    chk({name, ".d"},     32'(d_o),       32'(ed));
    chk({name, ".err"},   32'(d_err_o),   32'(ee));
    d_ready_i = 1'b1; cycles(1); d_ready_i = 1'b0;
  endtask

  // Expected FIFO entry {brk, frame, parity, data} derived from the line-level frame contents.
  function automatic logic [11:0] model_entry(input logic [8:0] data, input int nb, input logic pen,
                                              input logic podd, input logic pbit, input logic stop1);
    logic [8:0] m;
    int         ones;
    logic       perr;
    m    = data & 9'((1 << nb) - 1);
    ones = $countones(m) + int'(pbit);
    perr = pen && (((ones % 2) == 1) != podd);
    if (m == 9'd0 && !(pen && pbit) && !stop1) return {3'b110, 9'd0};
    return {1'b0, ~stop1, perr, m};
  endfunction

  initial begin
    logic [11:0] q[$];
    logic [11:0] e;
    int          nb, div, k, base;
    logic [8:0]  data;
    logic        pen, podd, pbit, stop1, s2;

    //            cfg  n  data    pen   podd  pbit  stop1 s2    div exp_d   exp_err
    vecs[0] = '{4'd8,  8, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 9'h0A5, 3'b000};
    vecs[1] = '{4'd7,  7, 9'h041, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4, 9'h041, 3'b001};
    vecs[2] = '{4'd9,  9, 9'h1FF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4, 9'h1FF, 3'b000};
    vecs[3] = '{4'd8,  8, 9'h055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 9'h055, 3'b010};
    vecs[4] = '{4'd3,  5, 9'h01B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 9'h01B, 3'b000};
    vecs[5] = '{4'd15, 9, 9'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 9'h100, 3'b000};
    vecs[6] = '{4'd6,  6, 9'h03F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4, 9'h03F, 3'b011};
    vecs[7] = '{4'd8,  8, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4, 9'h000, 3'b011};
    vecs[8] = '{4'd8,  8, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 9'h03C, 3'b000};
    vecs[9] = '{4'd5,  5, 9'h00A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5, 9'h00A, 3'b000};

    // Reset values
    cycles(3);
    chk("rst.rts_n",   32'(rts_n_o),   32'd1);
    chk("rst.d",       32'(d_o),       32'd0);
    chk("rst.err",     32'(d_err_o),   32'd0);
    chk("rst.valid",   32'(d_valid_o), 32'd0);
    chk("rst.level",   32'(level_o),   32'd0);
    chk("rst.full",    32'(full_o),    32'd0);
    chk("rst.empty",   32'(empty_o),   32'd1);
    chk("rst.overrun", 32'(overrun_o), 32'd0);
    chk("rst.break",   32'(break_o),   32'd0);
    rst_n = 1'b1; enable_i = 1'b1; cycles(4);
    chk("en.rts_n", 32'(rts_n_o), 32'd0);

    // Directed frame table
    foreach (vecs[i]) begin
      set_fmt(int'(vecs[i].dbits_cfg), vecs[i].pen, vecs[i].podd, vecs[i].s2, vecs[i].div);
      send_frame(vecs[i].data, vecs[i].nsend, vecs[i].pen, vecs[i].pbit, vecs[i].stop1, vecs[i].s2, vecs[i].div);
      chk($sformatf("vec%0d.level", i), 32'(level_o), 32'd1);
      pop_check($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_err);
      cycles(1);
      chk($sformatf("vec%0d.empty", i), 32'(empty_o), 32'd1);
    end

    // Long low line: one break entry and one break pulse
    set_fmt(8, 1'b0, 1'b0, 1'b0, 4);
    base = brk_cnt;
    rx_i = 1'b0; cycles(12 * OS * 4);
    chk("brk.level",  32'(level_o), 32'd1);
    chk("brk.pulses", 32'(brk_cnt - base), 32'd1);
    rx_i = 1'b1; cycles(2 * OS * 4);
    chk("brk.level_after",  32'(level_o), 32'd1);
    chk("brk.pulses_after", 32'(brk_cnt - base), 32'd1);
    pop_check("brk", 9'h000, 3'b110);

    // Glitch of three sample ticks is a false start
    rx_i = 1'b0; cycles(3 * 4); rx_i = 1'b1; cycles(2 * OS * 4);
    chk("glitch.level", 32'(level_o), 32'd0);
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    pop_check("glitch.next", 9'h03C, 3'b000);

    // Six frames without pops: RTS, full, overrun and same-cycle clear
    for (int f = 0; f < 6; f++) begin
      if (f == 5) clr_arm = 1'b1;
      send_frame(9'(8'h11 * (f + 1)), 8, 1'b0, 1'b0, 1'b1, 1'b0, 4);
      clr_arm = 1'b0;
      cycles(1);
      chk($sformatf("ovf%0d.level", f), 32'(level_o), 32'((f < 4) ? f + 1 : 4));
      chk($sformatf("ovf%0d.rts_n", f), 32'(rts_n_o), 32'((f >= 1) ? 1 : 0));
      chk($sformatf("ovf%0d.full", f),  32'(full_o),  32'((f >= 3) ? 1 : 0));
      chk($sformatf("ovf%0d.overrun", f), 32'(overrun_o), 32'((f >= 4) ? 1 : 0));
      if (f == 4) begin
        clr_pulse = 1'b1; cycles(1); clr_pulse = 1'b0; cycles(1);
        chk("ovf.cleared", 32'(overrun_o), 32'd0);
      end
    end
    for (int f = 0; f < 4; f++) pop_check($sformatf("ovf.pop%0d", f), 9'(8'h11 * (f + 1)), 3'b000);
    cycles(1);
    chk("ovf.empty", 32'(empty_o), 32'd1);
    clr_pulse = 1'b1; cycles(1); clr_pulse = 1'b0;

    // Enable dropped mid data bit discards the frame
    rx_i = 1'b0; cycles(OS * 4);
    rx_i = 1'b1; cycles(OS * 4);
    rx_i = 1'b0; cycles(OS * 2);
    enable_i = 1'b0; cycles(3);
    chk("dis.rts_n", 32'(rts_n_o), 32'd1);
    rx_i = 1'b1; cycles(10 * OS * 4);
    chk("dis.level", 32'(level_o), 32'd0);
    enable_i = 1'b1; cycles(8);
    chk("reen.rts_n", 32'(rts_n_o), 32'd0);
    send_frame(9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    pop_check("reen", 9'h081, 3'b000);

    // Randomised frames against the model queue
    for (int f = 0; f < 20; f++) begin
      nb    = int'($urandom_range(5, 9));
      div   = int'($urandom_range(1, 5));
      pen   = 1'($urandom_range(0, 1));
      podd  = 1'($urandom_range(0, 1));
      s2    = 1'($urandom_range(0, 1));
      data  = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom);
      pbit  = 1'($urandom_range(0, 1));
      stop1 = ($urandom_range(0, 4) != 0);
      set_fmt(nb, pen, podd, s2, div);
      e = model_entry(data, nb, pen, podd, pbit, stop1);
      if (q.size() < 4) q.push_back(e);
      send_frame(data, nb, pen, pbit, stop1, s2, div);
      chk($sformatf("rnd%0d.level", f), 32'(level_o), 32'(q.size()));
      k = int'($urandom_range(0, q.size()));
      for (int p = 0; p < k; p++) begin
        e = q.pop_front();
        pop_check($sformatf("rnd%0d.pop%0d", f, p), e[8:0], e[11:9]);
      end
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      pop_check("rnd.drain", e[8:0], e[11:9]);
    end
    cycles(2);
    chk("rnd.empty", 32'(empty_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
